// File: rtl/dot_stream_acc.sv
// Streaming signed dot product: N lane products per beat accumulated over BEATS beats,
// narrowed to O_W bits (wrap or saturate) and presented on a valid/ready output register.
module dot_stream_acc #(
    parameter int unsigned N     = 2,
    parameter int unsigned W     = 8,
    parameter int unsigned ACC_W = 32,
    parameter int unsigned O_W   = 32,
    parameter int unsigned BEATS = 4,
    parameter int unsigned SAT   = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [N-1:0][W-1:0]     arg_0,
    input  logic signed [N-1:0][W-1:0]     arg_1,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [0:0][O_W-1:0]     out_0,
    output logic                           out_ovf
);

    localparam int unsigned P_W   = 2 * W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned HI_W  = ACC_W - O_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    logic signed [ACC_W-1:0] acc;
    logic        [CNT_W-1:0] cnt;
    logic signed [ACC_W-1:0] beat_sum;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] total;
    logic        [HI_W-1:0]  hi;
    logic                    fits;
    logic        [O_W-1:0]   nar_val;
    logic                    nar_ovf;
    logic                    accept;
    logic                    last;

    // in_ready never looks at in_valid, so upstream may wait on it freely
    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign last     = (cnt == LAST);

    // Lane products are sign-extended to the accumulator width before summing
    always_comb begin
        beat_sum = '0;
        prod     = '0;
        for (int i = 0; i < int'(N); i++) begin
            prod     = P_W'($signed(arg_0[i])) * P_W'($signed(arg_1[i]));
            beat_sum = beat_sum + ACC_W'(prod);
        end
    end

    assign total = acc + beat_sum;
    assign hi    = total[ACC_W-1:O_W-1];
    assign fits  = (&hi) || !(|hi);

    // The value fits in O_W signed bits exactly when all bits above the output sign agree with it
    always_comb begin
        nar_val = total[O_W-1:0];
        nar_ovf = 1'b0;
        if ((SAT != 0) && !fits) begin
            nar_ovf = 1'b1;
            nar_val = total[ACC_W-1] ? {1'b1, {(O_W-1){1'b0}}} : {1'b0, {(O_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_0     <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // clr drops the partial vector but leaves any pending result untouched
            if (clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                if (last) begin
                    out_0     <= nar_val;
                    out_ovf   <= nar_ovf;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= total;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_stream_acc.sv
// Bench for dot_stream_acc: three instances (32-bit wrap, 16-bit saturate, 16-bit wrap)
// share stimulus and are checked against a beat-queue reference model plus fixed scenarios.
module tb_dot_stream_acc;

    localparam int N     = 2;
    localparam int W     = 8;
    localparam int BEATS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [N-1:0][W-1:0] arg_0 = '0;
    logic [N-1:0][W-1:0] arg_1 = '0;

    logic rdy_a, rdy_b, rdy_c;
    logic ov_a, ov_b, ov_c;
    logic ovf_a, ovf_b, ovf_c;
    logic [0:0][31:0] out_a;
    logic [0:0][15:0] out_b;
    logic [0:0][15:0] out_c;

    dot_stream_acc #(.N(N), .W(W), .ACC_W(32), .O_W(32), .BEATS(BEATS), .SAT(0)) u_full (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy_a),
        .arg_0(arg_0), .arg_1(arg_1), .out_valid(ov_a), .out_ready(out_ready),
        .out_0(out_a), .out_ovf(ovf_a));

    dot_stream_acc #(.N(N), .W(W), .ACC_W(32), .O_W(16), .BEATS(BEATS), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy_b),
        .arg_0(arg_0), .arg_1(arg_1), .out_valid(ov_b), .out_ready(out_ready),
        .out_0(out_b), .out_ovf(ovf_b));

    dot_stream_acc #(.N(N), .W(W), .ACC_W(32), .O_W(16), .BEATS(BEATS), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy_c),
        .arg_0(arg_0), .arg_1(arg_1), .out_valid(ov_c), .out_ready(out_ready),
        .out_0(out_c), .out_ovf(ovf_c));

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: accepted beat sums queued until a full vector is present
    int          m_beats[$];
    bit          m_valid = 1'b0;
    int          m_full = 0;
    logic [15:0] m_wrap = '0;
    logic [15:0] m_sat = '0;
    bit          m_sovf = 1'b0;

    function automatic int beat_sum();
        int s = 0;
        for (int i = 0; i < N; i++) begin
            s += int'($signed(arg_0[i])) * int'($signed(arg_1[i]));
        end
        return s;
    endfunction

    task automatic tick();
        bit exp_rdy;
        int total;
        exp_rdy = !rst && (!m_valid || out_ready);
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_beats.delete();
            m_full = 0;
            m_wrap = '0;
            m_sat = '0;
            m_sovf = 1'b0;
        end else begin
            if (m_valid && out_ready) m_valid = 1'b0;
            if (clr) begin
                m_beats.delete();
            end else if (in_valid && exp_rdy) begin
                m_beats.push_back(beat_sum());
                if (m_beats.size() == BEATS) begin
                    total = 0;
                    foreach (m_beats[k]) total += m_beats[k];
                    m_full = total;
                    m_wrap = total[15:0];
                    if (total > 32767) begin
                        m_sat = 16'h7fff;
                        m_sovf = 1'b1;
                    end else if (total < -32768) begin
                        m_sat = 16'h8000;
                        m_sovf = 1'b1;
                    end else begin
                        m_sat = total[15:0];
                        m_sovf = 1'b0;
                    end
                    m_valid = 1'b1;
                    m_beats.delete();
                end
            end
        end
        #1;
    endtask

    task automatic set_beat(input int a0, input int a1, input int b0, input int b1);
        arg_0[0] = W'(a0);
        arg_0[1] = W'(a1);
        arg_1[0] = W'(b0);
        arg_1[1] = W'(b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        set_beat(3, 4, 5, 6);
        tick();
        n_checks++;
        if (rdy_a !== 1'b0 || rdy_c !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready_low: got %b want 0", rdy_a);
        end
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({ov_a, ov_b, ov_c} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 000", {ov_a, ov_b, ov_c});
        end
        n_checks++;
        if (out_a[0] !== 32'd0 || out_b[0] !== 16'd0 || out_c[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_out_0: got %0d want 0", out_a[0]);
        end
        n_checks++;
        if ({ovf_a, ovf_b, ovf_c} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b want 000", {ovf_a, ovf_b, ovf_c});
        end
        n_checks++;
        if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || rdy_c !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready_high: got %b want 111", {rdy_a, rdy_b, rdy_c});
        end
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_beat(1, 2, 3, 4);
        for (int b = 0; b < 3; b++) begin
            tick();
            n_checks++;
            if (ov_a !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_early_valid: beat %0d got %b want 0", b, ov_a);
            end
        end
        tick();
        n_checks++;
        if (ov_a !== 1'b1 || out_a[0] !== 32'd44 || out_b[0] !== 16'd44 || out_c[0] !== 16'd44) begin
            n_fail++;
            $display("FAIL basic_result: got valid=%b out=%0d want valid=1 out=44", ov_a, out_a[0]);
        end
        n_checks++;
        if (rdy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready_while_draining: got %b want 1", rdy_a);
        end
        tick();
        n_checks++;
        if (ov_a !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: got %b want 0", ov_a);
        end
        for (int b = 0; b < 3; b++) tick();
        n_checks++;
        if (ov_a !== 1'b1 || out_a[0] !== 32'd44) begin
            n_fail++;
            $display("FAIL basic_second_vector: got valid=%b out=%0d want 1/44", ov_a, out_a[0]);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_narrow();
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_beat(-128, -128, -128, -128);
        for (int b = 0; b < BEATS; b++) tick();
        n_checks++;
        if (out_c[0] !== 16'h7fff || ovf_c !== 1'b1) begin
            n_fail++;
            $display("FAIL narrow_sat_pos: got %0d ovf=%b want 32767 ovf=1", $signed(out_c[0]), ovf_c);
        end
        n_checks++;
        if (out_b[0] !== 16'd0 || ovf_b !== 1'b0 || out_a[0] !== 32'd131072 || ovf_a !== 1'b0) begin
            n_fail++;
            $display("FAIL narrow_wrap_pos: got %0d/%0d ovf=%b want 0/131072 ovf=0", out_b[0], out_a[0], ovf_b);
        end
        set_beat(-128, -128, 127, 127);
        for (int b = 0; b < BEATS; b++) tick();
        n_checks++;
        if (out_c[0] !== 16'h8000 || ovf_c !== 1'b1) begin
            n_fail++;
            $display("FAIL narrow_sat_neg: got %0d ovf=%b want -32768 ovf=1", $signed(out_c[0]), ovf_c);
        end
        n_checks++;
        if (out_b[0] !== 16'd1024 || $signed(out_a[0]) !== -130048) begin
            n_fail++;
            $display("FAIL narrow_wrap_neg: got %0d/%0d want 1024/-130048", out_b[0], $signed(out_a[0]));
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_beat(1, 1, 1, 1);
        for (int b = 0; b < BEATS; b++) tick();
        out_ready = 1'b0;
        set_beat(3, 0, 1, 0);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (rdy_a !== 1'b0 || ov_a !== 1'b1 || out_a[0] !== 32'd8) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d ready=%b valid=%b out=%0d want 0/1/8", c, rdy_a, ov_a, out_a[0]);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (rdy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b want 1", rdy_a);
        end
        tick();
        n_checks++;
        if (ov_a !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release_drain: got %b want 0", ov_a);
        end
        set_beat(1, 0, 1, 0);
        for (int b = 0; b < 3; b++) tick();
        n_checks++;
        if (ov_a !== 1'b1 || out_a[0] !== 32'd6) begin
            n_fail++;
            $display("FAIL bp_next_vector: got valid=%b out=%0d want 1/6", ov_a, out_a[0]);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_clr();
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_beat(5, 5, 5, 5);
        tick();
        tick();
        clr = 1'b1;
        set_beat(9, 9, 9, 9);
        #1;
        n_checks++;
        if (rdy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_ready: got %b want 1", rdy_a);
        end
        tick();
        clr = 1'b0;
        set_beat(1, 1, 1, 1);
        for (int b = 0; b < BEATS; b++) tick();
        n_checks++;
        if (ov_a !== 1'b1 || out_a[0] !== 32'd8) begin
            n_fail++;
            $display("FAIL clr_result: got valid=%b out=%0d want 1/8", ov_a, out_a[0]);
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (ov_a !== 1'b1 || out_a[0] !== 32'd8 || ovf_c !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_pending: got valid=%b out=%0d want 1/8", ov_a, out_a[0]);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_beat(int'($urandom_range(0, 255)), 7, int'($urandom_range(0, 255)), 9);
        for (int b = 0; b < 3; b++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_beat(2, 0, 3, 0);
        for (int b = 0; b < 3; b++) begin
            tick();
            n_checks++;
            if (ov_a !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_stale: beat %0d got valid=%b want 0", b, ov_a);
            end
        end
        tick();
        n_checks++;
        if (ov_a !== 1'b1 || out_a[0] !== 32'd24) begin
            n_fail++;
            $display("FAIL midrst_result: got valid=%b out=%0d want 1/24", ov_a, out_a[0]);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N; i++) begin
                arg_0[i] = W'($urandom);
                arg_1[i] = W'($urandom);
            end
            #1;
            n_checks++;
            if (rdy_a !== (!m_valid || out_ready) || rdy_c !== rdy_a) begin
                n_fail++;
                $display("FAIL rand_ready: cycle %0d got %b want %b", c, rdy_a, (!m_valid || out_ready));
            end
            tick();
            n_checks++;
            if (ov_a !== m_valid || ov_b !== m_valid || ov_c !== m_valid) begin
                n_fail++;
                $display("FAIL rand_valid: cycle %0d got %b%b%b want %b", c, ov_a, ov_b, ov_c, m_valid);
            end
            if (m_valid) begin
                n_checks++;
                if (out_a[0] !== m_full || out_b[0] !== m_wrap || ovf_a !== 1'b0 || ovf_b !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_wrap: cycle %0d got %0d/%0d want %0d/%0d", c, $signed(out_a[0]),
                             out_b[0], m_full, m_wrap);
                end
                n_checks++;
                if (out_c[0] !== m_sat || ovf_c !== m_sovf) begin
                    n_fail++;
                    $display("FAIL rand_sat: cycle %0d got %0d ovf=%b want %0d ovf=%b", c, $signed(out_c[0]),
                             ovf_c, $signed(m_sat), m_sovf);
                end
            end
        end
        clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_narrow();
        test_backpressure();
        test_clr();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
